// File: rtl/tmr_scrub_if.sv
// ============================================================================
// tmr_scrub_if
// Replica-memory bus between the TMR scrub sequencer (master) and the three
// replicated memories (slave): one shared address, a read handshake returning
// all three replica words, and a write-back handshake carrying the voted word.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface tmr_scrub_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic              rd_req;
  logic              rd_ack;
  logic [DATA_W-1:0] rdA;
  logic [DATA_W-1:0] rdB;
  logic [DATA_W-1:0] rdC;
  logic              wr_req;
  logic              wr_ack;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output addr, rd_req, wr_req, wr_data,
    input  rd_ack, rdA, rdB, rdC, wr_ack
  );

  modport slave (
    input  addr, rd_req, wr_req, wr_data,
    output rd_ack, rdA, rdB, rdC, wr_ack
  );
endinterface

`default_nettype wire

// File: rtl/tmr_scrub_sequencer.sv
// ============================================================================
// tmr_scrub_sequencer
// Periodically sweeps a triple-replicated memory: reads each word from all
// three replicas, majority-votes it and writes the voted word back whenever
// any replica disagrees. Flags a sticky fatal when all three replicas differ.
// Optional feature macro: TMR_SCRUB_ERRCNT_EN adds a saturating 8-bit
// mismatch counter output (err_cnt).
// The start pulse is named force_sweep because "force" is a reserved word.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tmr_scrub_sequencer #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] interval,
  input  logic                force_sweep,
  output logic                busy,
  output logic                done,
  output logic                fatal,
`ifdef TMR_SCRUB_ERRCNT_EN
  output logic [7:0]          err_cnt,
`endif
  tmr_scrub_if.master         bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [2:0]          state;
  logic [ADDR_W-1:0]   addr_q;
  logic [PERIOD_W-1:0] count;
  logic [DATA_W-1:0]   cap_a;
  logic [DATA_W-1:0]   cap_b;
  logic [DATA_W-1:0]   cap_c;
  logic [DATA_W-1:0]   wr_data_q;

  logic [DATA_W-1:0]   voted;
  logic                mismatch;
  logic                all_differ;
  logic                last_word;
  logic [2:0]          adv_state;
  logic [ADDR_W-1:0]   adv_addr;

  // Vote on the captured replicas and work out where "advance" goes next
  always_comb begin
    voted      = (cap_a & cap_b) | (cap_b & cap_c) | (cap_a & cap_c);
    mismatch   = (cap_a != voted) || (cap_b != voted) || (cap_c != voted);
    all_differ = (cap_a != cap_b) && (cap_b != cap_c) && (cap_a != cap_c);
    last_word  = (addr_q == LAST_ADDR);
    adv_state  = ST_READ;
    adv_addr   = addr_q + 1'b1;
    if (last_word) begin
      adv_state = enable ? ST_WAIT : ST_IDLE;
      adv_addr  = '0;
    end
  end

  // Sweep sequencer: interval wait, read, vote, optional write-back
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      count     <= '0;
      cap_a     <= '0;
      cap_b     <= '0;
      cap_c     <= '0;
      wr_data_q <= '0;
      done      <= 1'b0;
      fatal     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            if (force_sweep) begin
              state  <= ST_READ;
              addr_q <= '0;
            end else begin
              state <= ST_WAIT;
              count <= interval;
            end
          end
        end
        ST_WAIT: begin
          // Dropping enable wins over a simultaneous force pulse
          if (!enable) begin
            state <= ST_IDLE;
          end else if ((count == '0) || force_sweep) begin
            state  <= ST_READ;
            addr_q <= '0;
          end else begin
            count <= count - 1'b1;
          end
        end
        ST_READ: begin
          if (bus.rd_ack) begin
            cap_a <= bus.rdA;
            cap_b <= bus.rdB;
            cap_c <= bus.rdC;
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (all_differ) begin
            fatal <= 1'b1;
          end
          if (mismatch) begin
            wr_data_q <= voted;
            state     <= ST_WRITE;
          end else begin
            state  <= adv_state;
            addr_q <= adv_addr;
            done   <= last_word;
            if (last_word) begin
              count <= interval;
            end
          end
        end
        ST_WRITE: begin
          if (bus.wr_ack) begin
            state  <= adv_state;
            addr_q <= adv_addr;
            done   <= last_word;
            if (last_word) begin
              count <= interval;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef TMR_SCRUB_ERRCNT_EN
  // Saturating count of words found with any replica disagreeing
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt <= 8'd0;
    end else if ((state == ST_CHECK) && mismatch && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

  // Requests and busy decode straight from the state register
  always_comb begin
    busy        = (state == ST_READ) || (state == ST_CHECK) || (state == ST_WRITE);
    bus.rd_req  = (state == ST_READ);
    bus.wr_req  = (state == ST_WRITE);
    bus.addr    = addr_q;
    bus.wr_data = wr_data_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_tmr_scrub_sequencer.sv
// ============================================================================
// tb_tmr_scrub_sequencer
// Directed bench for tmr_scrub_sequencer (DEPTH=4) with a three-replica
// memory model and acks driven combinationally from the requests.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tmr_scrub_sequencer;

  logic        clk;
  logic        rstn;
  logic        enable;
  logic [15:0] interval;
  logic        force_sweep;
  logic        busy;
  logic        done;
  logic        fatal;
`ifdef TMR_SCRUB_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  logic        rd_ack_en;
  logic        wr_ack_en;
  logic [7:0]  mem_a [4];
  logic [7:0]  mem_b [4];
  logic [7:0]  mem_c [4];

  int compared   = 0;
  int mismatched = 0;

  int n_reads    = 0;
  int n_writes   = 0;
  int n_done     = 0;
  int n_overlap  = 0;
  int cyc        = 0;
  int rd_addrs [$];
  int done_cyc [$];
  logic [3:0] last_wr_addr = '0;
  logic [7:0] last_wr_data = '0;

  tmr_scrub_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  tmr_scrub_sequencer #(
    .ADDR_W  (4),
    .DATA_W  (8),
    .DEPTH   (4),
    .PERIOD_W(16)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .enable     (enable),
    .interval   (interval),
    .force_sweep(force_sweep),
    .busy       (busy),
    .done       (done),
    .fatal      (fatal),
`ifdef TMR_SCRUB_ERRCNT_EN
    .err_cnt    (err_cnt),
`endif
    .bus        (bus)
  );

  // Replica memory model: immediate acks unless held off by the bench
  assign bus.rd_ack = bus.rd_req & rd_ack_en;
  assign bus.wr_ack = bus.wr_req & wr_ack_en;
  assign bus.rdA    = mem_a[bus.addr[1:0]];
  assign bus.rdB    = mem_b[bus.addr[1:0]];
  assign bus.rdC    = mem_c[bus.addr[1:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Transaction monitor sampled on the falling edge
  always @(negedge clk) begin
    if (bus.rd_req && bus.rd_ack) begin
      n_reads <= n_reads + 1;
      rd_addrs.push_back(int'(bus.addr));
    end
    if (bus.wr_req && bus.wr_ack) begin
      n_writes     <= n_writes + 1;
      last_wr_addr <= bus.addr;
      last_wr_data <= bus.wr_data;
    end
    if (done) begin
      n_done <= n_done + 1;
      done_cyc.push_back(cyc);
    end
    if (bus.rd_req && bus.wr_req) n_overlap <= n_overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    check(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_busy(input string tag, input int budget);
    int n;
    n = 0;
    while (busy !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, busy}, 32'd1);
  endtask

  task automatic pulse_force();
    force_sweep = 1'b1;
    @(negedge clk);
    force_sweep = 1'b0;
  endtask

  initial begin
    int r0, w0, q0, d0, t1, t2, t3, t4, n;

    rstn        = 1'b0;
    enable      = 1'b0;
    interval    = 16'd0;
    force_sweep = 1'b0;
    rd_ack_en   = 1'b1;
    wr_ack_en   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = 8'h10 + 8'(i);
      mem_b[i] = 8'h10 + 8'(i);
      mem_c[i] = 8'h10 + 8'(i);
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy",    {31'd0, busy},        32'd0);
    check("rst_rd_req",  {31'd0, bus.rd_req},  32'd0);
    check("rst_wr_req",  {31'd0, bus.wr_req},  32'd0);
    check("rst_done",    {31'd0, done},        32'd0);
    check("rst_fatal",   {31'd0, fatal},       32'd0);
    check("rst_addr",    {28'd0, bus.addr},    32'd0);
    check("rst_wr_data", {24'd0, bus.wr_data}, 32'd0);
`ifdef TMR_SCRUB_ERRCNT_EN
    check("rst_err_cnt", {24'd0, err_cnt},     32'd0);
`endif
    rstn = 1'b1;
    @(negedge clk);
    check("idle_disabled_busy", {31'd0, busy}, 32'd0);

    // Clean sweep started by force
    interval = 16'd1000;
    enable   = 1'b1;
    r0 = n_reads; w0 = n_writes; q0 = rd_addrs.size(); d0 = n_done;
    pulse_force();
    check("clean_busy", {31'd0, busy}, 32'd1);
    wait_done("clean_done", 40);
    check("clean_reads",  n_reads - r0,  32'd4);
    check("clean_writes", n_writes - w0, 32'd0);
    if (rd_addrs.size() >= q0 + 4) begin
      for (int k = 0; k < 4; k++) check($sformatf("clean_addr%0d", k), rd_addrs[q0 + k], k);
    end else begin
      check("clean_addr_count", rd_addrs.size() - q0, 32'd4);
    end
    @(negedge clk);
    check("clean_done_pulse", {31'd0, done}, 32'd0);
    check("clean_done_once",  n_done - d0,   32'd1);
    check("clean_idle_busy",  {31'd0, busy}, 32'd0);
    check("clean_fatal",      {31'd0, fatal}, 32'd0);

    // Single-replica upset in word 2
    mem_a[2] = 8'h5A; mem_b[2] = 8'h5A; mem_c[2] = 8'h00;
    w0 = n_writes;
    pulse_force();
    wait_done("upset_done", 60);
    check("upset_writes",  n_writes - w0,          32'd1);
    check("upset_wr_addr", {28'd0, last_wr_addr},  32'd2);
    check("upset_wr_data", {24'd0, last_wr_data},  32'h5A);
    check("upset_fatal",   {31'd0, fatal},         32'd0);
`ifdef TMR_SCRUB_ERRCNT_EN
    check("upset_err_cnt", {24'd0, err_cnt},       32'd1);
`endif
    mem_c[2] = 8'h5A;

    // Triple disagreement in word 1
    mem_a[1] = 8'h01; mem_b[1] = 8'h02; mem_c[1] = 8'h04;
    w0 = n_writes;
    pulse_force();
    wait_done("fatal_done", 60);
    check("fatal_writes",  n_writes - w0,         32'd1);
    check("fatal_wr_addr", {28'd0, last_wr_addr}, 32'd1);
    check("fatal_wr_data", {24'd0, last_wr_data}, 32'h00);
    check("fatal_set",     {31'd0, fatal},        32'd1);
    mem_a[1] = 8'h11; mem_b[1] = 8'h11; mem_c[1] = 8'h11;
    w0 = n_writes;
    pulse_force();
    wait_done("sticky_done", 60);
    check("sticky_writes", n_writes - w0,  32'd0);
    check("sticky_fatal",  {31'd0, fatal}, 32'd1);
`ifdef TMR_SCRUB_ERRCNT_EN
    check("sticky_err_cnt", {24'd0, err_cnt}, 32'd2);
`endif

    // Periodic sweeps: 8-cycle sweep plus 6 WAIT cycles at interval 5
    interval = 16'd5;
    pulse_force();
    wait_done("per_done1", 60);
    t1 = done_cyc[$];
    r0 = n_reads;
    wait_busy("per_busy", 20);
    pulse_force();
    wait_done("per_done2", 60);
    t2 = done_cyc[$];
    check("per_spacing5",  t2 - t1,      32'd14);
    check("per_no_restart", n_reads - r0, 32'd4);
    interval = 16'd0;
    wait_done("per_done3", 60);
    t3 = done_cyc[$];
    check("per_spacing_reload", t3 - t2, 32'd14);
    wait_done("per_done4", 60);
    t4 = done_cyc[$];
    check("per_spacing0", t4 - t3, 32'd9);

    // Enable dropped mid-sweep: sweep completes then idles
    wait_busy("drop_busy", 20);
    enable = 1'b0;
    d0 = n_done;
    wait_done("drop_done", 60);
    r0 = n_reads;
    repeat (20) @(negedge clk);
    check("drop_done_once", n_done - d0,   32'd1);
    check("drop_idle_busy", {31'd0, busy}, 32'd0);
    check("drop_no_reads",  n_reads - r0,  32'd0);

    // Reset in the middle of a stalled write-back
    mem_a[0] = 8'h33; mem_b[0] = 8'h33; mem_c[0] = 8'h30;
    wr_ack_en = 1'b0;
    rd_ack_en = 1'b0;
    interval  = 16'd100;
    enable    = 1'b1;
    pulse_force();
    repeat (2) @(negedge clk);
    check("stall_rd_req", {31'd0, bus.rd_req}, 32'd1);
    check("stall_addr",   {28'd0, bus.addr},   32'd0);
    check("stall_busy",   {31'd0, busy},       32'd1);
    rd_ack_en = 1'b1;
    n = 0;
    while (bus.wr_req !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("wr_req_seen",   {31'd0, bus.wr_req},  32'd1);
    check("wr_addr0",      {28'd0, bus.addr},    32'd0);
    check("wr_data33",     {24'd0, bus.wr_data}, 32'h33);
    check("wr_no_rd_req",  {31'd0, bus.rd_req},  32'd0);
    w0 = n_writes;
    repeat (3) @(negedge clk);
    check("wr_req_held",   {31'd0, bus.wr_req},  32'd1);
    rstn = 1'b0;
    #1;
    check("arst_wr_req",  {31'd0, bus.wr_req},  32'd0);
    check("arst_rd_req",  {31'd0, bus.rd_req},  32'd0);
    check("arst_busy",    {31'd0, busy},        32'd0);
    check("arst_done",    {31'd0, done},        32'd0);
    check("arst_fatal",   {31'd0, fatal},       32'd0);
    check("arst_addr",    {28'd0, bus.addr},    32'd0);
    check("arst_wr_data", {24'd0, bus.wr_data}, 32'd0);
    check("arst_no_write", n_writes - w0,       32'd0);
`ifdef TMR_SCRUB_ERRCNT_EN
    check("arst_err_cnt", {24'd0, err_cnt},     32'd0);
`endif
    @(negedge clk);
    mem_a[0] = 8'h10; mem_b[0] = 8'h10; mem_c[0] = 8'h10;
    wr_ack_en = 1'b1;
    rstn = 1'b1;
    r0 = n_reads; w0 = n_writes; q0 = rd_addrs.size();
    pulse_force();
    wait_done("restart_done", 40);
    check("restart_reads",  n_reads - r0,  32'd4);
    check("restart_writes", n_writes - w0, 32'd0);
    if (rd_addrs.size() > q0) check("restart_addr0", rd_addrs[q0], 32'd0);
    else check("restart_addr_count", rd_addrs.size() - q0, 32'd4);
    check("restart_fatal", {31'd0, fatal}, 32'd0);

`ifdef TMR_SCRUB_ERRCNT_EN
    // Saturation: 76 sweeps of 4 mismatching words
    for (int i = 0; i < 4; i++) mem_c[i] = mem_a[i] ^ 8'h01;
    interval = 16'd0;
    pulse_force();
    for (int s = 0; s < 76; s++) wait_done("sat_done", 40);
    check("sat_err_cnt", {24'd0, err_cnt}, 32'd255);
    check("sat_fatal",   {31'd0, fatal},   32'd0);
    for (int i = 0; i < 4; i++) mem_c[i] = mem_a[i];
`endif

    check("no_rd_wr_overlap", n_overlap, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
